// File: rtl/calc_pkg.sv
// Shared constants and types for the keypad front end and calculator datapath:
// operator encodings, special key indices, matrix geometry and FSM/scan enums.
package calc_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;

    localparam int KEY_ADD = 16;
    localparam int KEY_MUL = 17;
    localparam int KEY_SUB = 18;
    localparam int KEY_EQ  = 19;

    localparam int NUM_COLS = 5;
    localparam int NUM_ROWS = 4;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_PEND   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_PEND = 2'd3
    } db_state_e;

    typedef enum logic [1:0] {
        SCAN_NONE   = 2'd0,
        SCAN_SINGLE = 2'd1,
        SCAN_MULTI  = 2'd2
    } scan_res_e;

endpackage

// File: rtl/keypad_decoder_if.sv
// Keypad pin and key-event bundle; master is the decoder, slave is the keypad/consumer side.
interface keypad_decoder_if;
    logic [3:0] row_n;
    logic [4:0] col_n;
    logic       newhex;
    logic [3:0] hexcode;
    logic       newop;
    logic [1:0] opcode;
    logic       eq;

    modport master (
        input  row_n,
        output col_n, newhex, hexcode, newop, opcode, eq
    );

    modport slave (
        output row_n,
        input  col_n, newhex, hexcode, newop, opcode, eq
    );
endinterface

// File: rtl/keypad_scanner.sv
// Column scanner: synchronizes rows, walks a single low column and classifies each
// full sweep as NONE/SINGLE/MULTI, strobing scan_done while column 4 is sampled.
module keypad_scanner
    import calc_pkg::*;
#(
    parameter int SCAN_DIV = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row_n,
    output logic [4:0] col_n,
    output logic       scan_done,
    output scan_res_e  scan_res,
    output logic [4:0] scan_key
);
    localparam int DIV_W = $clog2(SCAN_DIV);

    logic [DIV_W-1:0] div_cnt_r;
    logic [2:0]       col_r;
    logic [4:0]       col_n_r;
    logic [3:0]       row_meta_r;
    logic [3:0]       row_sync_r;
    logic [1:0]       acc_cnt_r;
    logic [4:0]       acc_key_r;

    logic             sample_s;
    logic             last_col_s;
    logic [3:0]       pressed_s;
    logic [2:0]       row_hits_s;
    logic [1:0]       row_idx_s;
    logic [2:0]       sum_s;
    logic [1:0]       tot_cnt_s;
    logic [4:0]       tot_key_s;

    assign sample_s   = (div_cnt_r == DIV_W'(SCAN_DIV - 1));
    assign last_col_s = (col_r == 3'(NUM_COLS - 1));
    assign pressed_s  = ~row_sync_r;

    // Two-flop synchronizer for the asynchronous row inputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row_meta_r <= 4'b1111;
            row_sync_r <= 4'b1111;
        end else begin
            row_meta_r <= row_n;
            row_sync_r <= row_meta_r;
        end
    end

    // Dwell counter and column walk; col_n rotates so exactly one bit is ever low
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt_r <= '0;
            col_r     <= 3'd0;
            col_n_r   <= 5'b11110;
        end else if (sample_s) begin
            div_cnt_r <= '0;
            col_n_r   <= {col_n_r[3:0], col_n_r[4]};
            col_r     <= last_col_s ? 3'd0 : col_r + 3'd1;
        end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
        end
    end

    // Count pressed rows in the current column and remember the lowest one
    always_comb begin
        row_hits_s = 3'd0;
        row_idx_s  = 2'd0;
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (pressed_s[r]) begin
                row_hits_s = row_hits_s + 3'd1;
                row_idx_s  = 2'(r);
            end else begin
                row_hits_s = row_hits_s;
            end
        end
    end

    // Merge this column into the sweep tally; the count saturates at 2 (MULTI)
    always_comb begin
        sum_s     = {1'b0, acc_cnt_r} + row_hits_s;
        tot_cnt_s = (sum_s >= 3'd2) ? 2'd2 : sum_s[1:0];
        if (acc_cnt_r == 2'd0) begin
            tot_key_s = {col_r[2:0], row_idx_s};
        end else begin
            tot_key_s = acc_key_r;
        end
    end

    // Per-sweep accumulators, cleared once the sweep result has been handed off
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_cnt_r <= 2'd0;
            acc_key_r <= 5'd0;
        end else if (sample_s) begin
            acc_cnt_r <= last_col_s ? 2'd0 : tot_cnt_s;
            acc_key_r <= last_col_s ? 5'd0 : tot_key_s;
        end else begin
            acc_cnt_r <= acc_cnt_r;
            acc_key_r <= acc_key_r;
        end
    end

    // Sweep result is valid combinationally alongside the column-4 sample
    always_comb begin
        scan_done = sample_s && last_col_s;
        scan_key  = tot_key_s;
        case (tot_cnt_s)
            2'd0:    scan_res = SCAN_NONE;
            2'd1:    scan_res = SCAN_SINGLE;
            default: scan_res = SCAN_MULTI;
        endcase
    end

    assign col_n = col_n_r;

endmodule

// File: rtl/keypad_decoder.sv
// Matrix keypad decoder: debounces sweep results from keypad_scanner and emits one
// registered newhex/newop/eq pulse per confirmed press, with no auto-repeat.
module keypad_decoder
    import calc_pkg::*;
#(
    parameter int SCAN_DIV       = 4,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic clock,
    input  logic reset,
    keypad_decoder_if.master kp
);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    logic             scan_done_s;
    scan_res_e        scan_res_s;
    logic [4:0]       scan_key_s;
    logic             single_s;
    logic             none_s;

    db_state_e        st_r, st_n;
    logic [4:0]       cand_r, cand_n;
    logic [CNT_W-1:0] cnt_r, cnt_n, cnt_inc_s;
    logic             fire_s;

    logic             newhex_r, newop_r, eq_r;
    logic [3:0]       hexcode_r;
    logic [1:0]       opcode_r;

    keypad_scanner #(.SCAN_DIV(SCAN_DIV)) u_scanner (
        .clock     (clock),
        .reset     (reset),
        .row_n     (kp.row_n),
        .col_n     (kp.col_n),
        .scan_done (scan_done_s),
        .scan_res  (scan_res_s),
        .scan_key  (scan_key_s)
    );

    assign single_s  = (scan_res_s == SCAN_SINGLE);
    assign none_s    = (scan_res_s == SCAN_NONE);
    assign cnt_inc_s = cnt_r + CNT_W'(1);

    // Debounce transitions, evaluated only on the sweep-complete strobe
    always_comb begin
        st_n   = st_r;
        cand_n = cand_r;
        cnt_n  = cnt_r;
        fire_s = 1'b0;
        if (scan_done_s) begin
            case (st_r)
                ST_IDLE: begin
                    if (single_s) begin
                        st_n   = ST_PRESS_PEND;
                        cand_n = scan_key_s;
                        cnt_n  = CNT_W'(1);
                    end else begin
                        st_n = ST_IDLE;
                    end
                end
                ST_PRESS_PEND: begin
                    if (single_s && (scan_key_s == cand_r)) begin
                        if (cnt_inc_s == CNT_W'(DEBOUNCE_SCANS)) begin
                            fire_s = 1'b1;
                            st_n   = ST_HELD;
                            cnt_n  = '0;
                        end else begin
                            cnt_n = cnt_inc_s;
                        end
                    end else if (single_s) begin
                        cand_n = scan_key_s;
                        cnt_n  = CNT_W'(1);
                    end else begin
                        st_n  = ST_IDLE;
                        cnt_n = '0;
                    end
                end
                // Extra keys while held are deliberately ignored until a clean release
                ST_HELD: begin
                    if (none_s) begin
                        st_n  = ST_RELEASE_PEND;
                        cnt_n = CNT_W'(1);
                    end else begin
                        st_n = ST_HELD;
                    end
                end
                ST_RELEASE_PEND: begin
                    if (none_s) begin
                        if (cnt_inc_s == CNT_W'(DEBOUNCE_SCANS)) begin
                            st_n  = ST_IDLE;
                            cnt_n = '0;
                        end else begin
                            cnt_n = cnt_inc_s;
                        end
                    end else begin
                        st_n  = ST_HELD;
                        cnt_n = '0;
                    end
                end
                default: begin
                    st_n  = ST_IDLE;
                    cnt_n = '0;
                end
            endcase
        end else begin
            st_n = st_r;
        end
    end

    // Debounce state registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st_r   <= ST_IDLE;
            cand_r <= 5'd0;
            cnt_r  <= '0;
        end else begin
            st_r   <= st_n;
            cand_r <= cand_n;
            cnt_r  <= cnt_n;
        end
    end

    // Event encoding; the code output not addressed by the event keeps its value
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            newhex_r  <= 1'b0;
            newop_r   <= 1'b0;
            eq_r      <= 1'b0;
            hexcode_r <= 4'd0;
            opcode_r  <= 2'd0;
        end else begin
            newhex_r <= fire_s && (cand_r < 5'(KEY_ADD));
            newop_r  <= fire_s && (cand_r >= 5'(KEY_ADD)) && (cand_r <= 5'(KEY_SUB));
            eq_r     <= fire_s && (cand_r == 5'(KEY_EQ));
            if (fire_s && (cand_r < 5'(KEY_ADD))) begin
                hexcode_r <= cand_r[3:0];
            end
            if (fire_s && (cand_r >= 5'(KEY_ADD)) && (cand_r <= 5'(KEY_SUB))) begin
                opcode_r <= cand_r[1:0];
            end
        end
    end

    assign kp.newhex  = newhex_r;
    assign kp.newop   = newop_r;
    assign kp.eq      = eq_r;
    assign kp.hexcode = hexcode_r;
    assign kp.opcode  = opcode_r;

endmodule

// File: tb/tb_keypad_decoder.sv
// Self-checking bench for keypad_decoder: a keypad matrix model drives row_n and a
// scan-history debounce reference predicts events after every full scan.
module tb_keypad_decoder;
    import calc_pkg::*;

    localparam int SD   = 4;
    localparam int DB   = 3;
    localparam int SCAN = 5 * SD;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [19:0] pressed = 20'd0;
    logic [3:0]  row_s;

    int checks = 0;
    int failures = 0;
    int pulse_cnt = 0;
    int exp_pulse_cnt = 0;

    int   hist_kind[$];
    int   hist_key[$];
    bit   m_held;
    logic [3:0] m_hex;
    logic [1:0] m_op;
    logic [2:0] m_pulse;
    logic [8:0] exp_v;
    logic [8:0] obs_v;

    always #5 clock = ~clock;

    keypad_decoder_if kif();

    keypad_decoder #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
        .clock (clock),
        .reset (reset),
        .kp    (kif)
    );

    // Passive keypad: a pressed key shorts its row to the currently driven column
    always_comb begin
        row_s = 4'b1111;
        for (int c = 0; c < 5; c++)
            for (int r = 0; r < 4; r++)
                if (pressed[c*4+r] && !kif.col_n[c]) row_s[r] = 1'b0;
    end
    assign kif.row_n = row_s;

    always @(negedge clock)
        if (!reset) pulse_cnt += int'(kif.newhex) + int'(kif.newop) + int'(kif.eq);

    function automatic logic [19:0] kb(input int i);
        logic [19:0] one;
        one = 20'd1;
        return one << i;
    endfunction

    task automatic model_reset();
        hist_kind.delete();
        hist_key.delete();
        m_held = 1'b0;
        m_hex  = 4'd0;
        m_op   = 2'd0;
    endtask

    // Reference: fire when the last DB scans are the same single key while not held;
    // a hold ends when the last DB scans saw no key at all.
    task automatic model_scan(input logic [19:0] keys);
        int n, k, kind, streak;
        n = $countones(keys);
        k = 0;
        for (int i = 0; i < 20; i++) if (keys[i]) k = i;
        kind = (n == 0) ? 0 : ((n == 1) ? 1 : 2);
        hist_kind.push_back(kind);
        hist_key.push_back(k);
        m_pulse = 3'b000;
        streak = 0;
        if (!m_held) begin
            if (kind == 1) begin
                for (int i = hist_kind.size() - 1; i >= 0; i--) begin
                    if (hist_kind[i] == 1 && hist_key[i] == k) streak++;
                    else break;
                end
                if (streak == DB) begin
                    m_held = 1'b1;
                    exp_pulse_cnt++;
                    if (k < 16) begin
                        m_pulse = 3'b100;
                        m_hex   = 4'(k);
                    end else if (k < 19) begin
                        m_pulse = 3'b010;
                        m_op    = 2'(k - 16);
                    end else begin
                        m_pulse = 3'b001;
                    end
                end
            end
        end else if (kind == 0) begin
            for (int i = hist_kind.size() - 1; i >= 0; i--) begin
                if (hist_kind[i] == 0) streak++;
                else break;
            end
            if (streak == DB) m_held = 1'b0;
        end
        exp_v = {m_pulse, m_hex, m_op};
    endtask

    // Holds keys for one full scan starting at column 0, samples the cycle after column 4
    task automatic run_scan(input logic [19:0] keys);
        pressed = keys;
        repeat (SCAN) @(posedge clock);
        #1;
        obs_v = {kif.newhex, kif.newop, kif.eq, kif.hexcode, kif.opcode};
        model_scan(keys);
    endtask

    task automatic test_reset();
        logic [13:0] got;
        logic [4:0]  exp_col;
        model_reset();
        #1 reset = 1'b1;
        #10;
        got = {kif.col_n, kif.newhex, kif.newop, kif.eq, kif.hexcode, kif.opcode};
        checks++;
        if (got !== {5'b11110, 9'd0}) begin
            failures++;
            $display("FAIL reset_state got %b want %b", got, {5'b11110, 9'd0});
        end
        @(negedge clock) reset = 1'b0;
        repeat (7) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        got = {kif.col_n, kif.newhex, kif.newop, kif.eq, kif.hexcode, kif.opcode};
        checks++;
        if (got !== {5'b11110, 9'd0}) begin
            failures++;
            $display("FAIL async_reset got %b want %b", got, {5'b11110, 9'd0});
        end
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b0;
        model_reset();
        for (int i = 1; i <= SCAN; i++) begin
            @(posedge clock);
            #1;
            if (i % SD == 0) begin
                exp_col = ~(5'b00001 << ((i / SD) % 5));
                checks++;
                if (kif.col_n !== exp_col) begin
                    failures++;
                    $display("FAIL col_step cycle %0d got %b want %b", i, kif.col_n, exp_col);
                end
            end
        end
        obs_v = {kif.newhex, kif.newop, kif.eq, kif.hexcode, kif.opcode};
        model_scan(20'd0);
        checks++;
        if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL idle_scan got %b want %b", obs_v, exp_v);
        end
    endtask

    task automatic test_hold_release();
        for (int s = 0; s < 16; s++) begin
            run_scan((s < 8 || s >= 12) ? kb(10) : 20'd0);
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL hold_release scan %0d got %b want %b", s, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_bounce();
        for (int s = 0; s < 9; s++) begin
            run_scan((s >= 6 || s % 2 == 0) ? kb(7) : 20'd0);
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL bounce scan %0d got %b want %b", s, obs_v, exp_v);
            end
        end
        for (int s = 0; s < 3; s++) run_scan(20'd0);
    endtask

    task automatic test_ops();
        int keys[3] = '{KEY_MUL, KEY_EQ, KEY_SUB};
        for (int k = 0; k < 3; k++) begin
            for (int s = 0; s < 6; s++) begin
                run_scan((s < 3) ? kb(keys[k]) : 20'd0);
                checks++;
                if (obs_v !== exp_v) begin
                    failures++;
                    $display("FAIL ops key %0d scan %0d got %b want %b", keys[k], s, obs_v, exp_v);
                end
            end
        end
    endtask

    task automatic test_multi();
        logic [19:0] pat;
        for (int s = 0; s < 12; s++) begin
            if (s < 3)       pat = kb(3) | kb(5);
            else if (s < 6)  pat = kb(3);
            else if (s < 9)  pat = kb(3) | kb(9);
            else             pat = 20'd0;
            run_scan(pat);
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL multi scan %0d got %b want %b", s, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_reset_pending();
        for (int s = 0; s < 2; s++) begin
            run_scan(kb(12));
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL pend_pre scan %0d got %b want %b", s, obs_v, exp_v);
            end
        end
        pressed = kb(12);
        repeat (9) @(posedge clock);
        #2 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({kif.newhex, kif.newop, kif.eq} !== 3'b000) begin
                failures++;
                $display("FAIL pend_in_reset got %b want 000", {kif.newhex, kif.newop, kif.eq});
            end
            @(posedge clock);
        end
        @(negedge clock) reset = 1'b0;
        model_reset();
        for (int s = 0; s < 6; s++) begin
            run_scan((s < 3) ? kb(12) : 20'd0);
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL pend_post scan %0d got %b want %b", s, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_random();
        logic [19:0] cur;
        int r, a, b;
        cur = 20'd0;
        for (int s = 0; s < 40; s++) begin
            r = int'($urandom_range(0, 9));
            if (r >= 5 && r <= 6) begin
                cur = 20'd0;
            end else if (r >= 7 && r <= 8) begin
                cur = kb(int'($urandom_range(0, 19)));
            end else if (r == 9) begin
                a = int'($urandom_range(0, 19));
                b = (a + 1 + int'($urandom_range(0, 18))) % 20;
                cur = kb(a) | kb(b);
            end
            run_scan(cur);
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL random scan %0d keys %h got %b want %b", s, cur, obs_v, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_hold_release();
        test_bounce();
        test_ops();
        test_multi();
        test_reset_pending();
        test_random();
        run_scan(20'd0);
        checks++;
        if (pulse_cnt !== exp_pulse_cnt) begin
            failures++;
            $display("FAIL pulse_total got %0d want %0d", pulse_cnt, exp_pulse_cnt);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
